// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: serial hex dump of a small register file over an 8N1 UART.
// On a one-cycle start pulse (accepted only while idle) the block walks
// addresses 0..NUM_REGS-1, reads each 4-bit entry, turns it into an ASCII hex
// character ('0'-'9', 'A'-'F') and shifts it out LSB first on tx.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      asynchronous active-low reset
//   start    dump request pulse, ignored while a dump is in progress
//   rd_addr  register-file read address (registered address counter)
//   rd_data  combinational register-file read data for rd_addr
//   tx       UART serial output, idles high
//   busy     high from the cycle after start is accepted until back in idle
//   done     one-cycle pulse when the whole dump has been sent
//
// Latency: 2 + 10*CLKS_PER_BIT cycles per register character.
// Backpressure: none; a start that arrives while busy is dropped, not queued.
//
// Optional build macro REGFILE_DUMP_CRLF_EN: after the last register frame,
// send a CR (0x0D) and LF (0x0A) trailer, each costing 1 + 10*CLKS_PER_BIT
// cycles (no settle cycle, the data is a constant). done follows the LF frame.

module regfile_dump_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 4,
  parameter int NUM_REGS     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [3:0]        rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  // Baud counter is at least one bit wide so CLKS_PER_BIT=1 still elaborates.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              bit_end;

`ifdef REGFILE_DUMP_CRLF_EN
  // Which character the current frame carries: a register, or a trailer byte.
  typedef enum logic [1:0] {
    CH_REG,
    CH_CR,
    CH_LF
  } char_t;

  char_t char_sel;
`endif

  // Last cycle of the current bit period.
  assign bit_end = (baud_cnt == BAUD_LAST);

  // 0-9 -> '0'-'9' (0x30-0x39), A-F -> 'A'-'F' (0x41-0x46).
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGFILE_DUMP_CRLF_EN
      char_sel  <= CH_REG;
`endif
    end else begin
      // done is a single-cycle pulse; only the final STOP edge raises it.
      done <= 1'b0;

      // Baud counter only runs while a frame is on the wire and reloads at
      // every bit boundary, so tx can only change on those boundaries.
      if (state == S_START || state == S_DATA || state == S_STOP) begin
        if (bit_end) begin
          baud_cnt <= '0;
        end else begin
          baud_cnt <= baud_cnt + BAUD_W'(1);
        end
      end else begin
        baud_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            rd_addr  <= '0;
            busy     <= 1'b1;
            state    <= S_SETTLE;
`ifdef REGFILE_DUMP_CRLF_EN
            char_sel <= CH_REG;
`endif
          end
        end

        // One cycle for the register file to present data for rd_addr.
        S_SETTLE: begin
          state <= S_LOAD;
        end

        // The entry is sampled here, so a write landing before this cycle
        // is what goes out on the wire.
        S_LOAD: begin
`ifdef REGFILE_DUMP_CRLF_EN
          case (char_sel)
            CH_CR:   shift_reg <= 8'h0D;
            CH_LF:   shift_reg <= 8'h0A;
            default: shift_reg <= hex_ascii(rd_data);
          endcase
`else
          shift_reg <= hex_ascii(rd_data);
`endif
          tx    <= 1'b0;
          state <= S_START;
        end

        S_START: begin
          if (bit_end) begin
            tx        <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= '0;
            state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
        end

        S_STOP: begin
          if (bit_end) begin
`ifdef REGFILE_DUMP_CRLF_EN
            if (char_sel == CH_REG && rd_addr != ADDR_LAST) begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= S_SETTLE;
            end else if (char_sel == CH_REG) begin
              // Final address stays on rd_addr through the trailer.
              char_sel <= CH_CR;
              state    <= S_LOAD;
            end else if (char_sel == CH_CR) begin
              char_sel <= CH_LF;
              state    <= S_LOAD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
`else
            if (rd_addr != ADDR_LAST) begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= S_SETTLE;
            end else begin
              // Address is held at the last entry, never wraps.
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
`endif
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
